// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: sink for the PPU pixel-write stream.
// Accepts in-window pixels in frame order, buffers them in a small FIFO,
// packs them to RGB565 and issues single-word framebuffer writes over a
// req/ack handshake. Drops data until a frame start and re-syncs after
// overflow or an out-of-sequence address.
//
// Optional build macro: PPU_FB_STATS_EN
//   defined   - overflow / addr_err / drop_cnt status is implemented
//   undefined - those outputs are tied to 0 (drop/re-sync behaviour unchanged)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_SYNC | not frame-aligned; discard pixels until ppu_addr == BASE
// ST_RUN  | aligned; accept pixels whose address equals expect_q
module ppu_fb_writer #(
  parameter logic [23:0] BASE   = 24'hf00000,
  parameter int unsigned PIXELS = 130560,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        clk_PPU,
  input  logic        n_reset_in,
  input  logic        in_valid,
  input  logic [23:0] ppu_addr,
  input  logic [23:0] ppu_rgb,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        frame_done,
  output logic        synced,
  output logic        overflow,
  output logic        addr_err,
  output logic [15:0] drop_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [23:0] LAST = BASE + 24'(PIXELS - 1);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t      state_q;
  logic [23:0] expect_q;
  logic [AW:0] rd_q, wr_q, rd_d, wr_d;
  logic [39:0] fifo_q [DEPTH];

  logic        mem_req_q, mem_req_d;
  logic [23:0] mem_addr_q;
  logic [15:0] mem_data_q;
  logic [39:0] head_d;
  logic        frame_done_q;

  logic        full, pop, hit, push, drop, mismatch;
  logic [15:0] pix565;

  // Low colour bits are discarded by the RGB565 packing.
  logic unused_rgb_lsbs;
  assign unused_rgb_lsbs = ^{ppu_rgb[18:16], ppu_rgb[9:8], ppu_rgb[2:0]};

  // Decode of the incoming pixel against FSM state and FIFO occupancy.
  always_comb begin
    pix565   = {ppu_rgb[23:19], ppu_rgb[15:10], ppu_rgb[7:3]};
    pop      = mem_req_q & mem_ack;
    full     = (rd_q[AW-1:0] == wr_q[AW-1:0]) && (rd_q[AW] != wr_q[AW]);
    mismatch = in_valid && (state_q == ST_RUN) && (ppu_addr != expect_q);
    hit      = 1'b0;
    if (in_valid) begin
      if (state_q == ST_SYNC) hit = (ppu_addr == BASE);
      else                    hit = (ppu_addr == expect_q) || (ppu_addr == BASE);
    end
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    push = hit & (~full | pop);
    drop = hit & full & ~pop;
    rd_d = rd_q + (AW+1)'(pop);
    wr_d = wr_q + (AW+1)'(push);
  end

  // Frame-alignment FSM: tracks the next expected address.
  always_ff @(posedge clk_PPU or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q  <= ST_SYNC;
      expect_q <= BASE;
    end else if (in_valid) begin
      case (state_q)
        ST_SYNC: begin
          if (hit && !drop) begin
            state_q  <= ST_RUN;
            expect_q <= BASE + 24'd1;
          end
        end
        ST_RUN: begin
          if (drop) begin
            state_q <= ST_SYNC;
          end else if (!mismatch) begin
            expect_q <= (ppu_addr == LAST) ? BASE : expect_q + 24'd1;
          end else if (ppu_addr == BASE) begin
            expect_q <= BASE + 24'd1;
          end else begin
            state_q <= ST_SYNC;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign synced = (state_q == ST_RUN);

  // FIFO storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk_PPU) begin
    if (push) fifo_q[wr_q[AW-1:0]] <= {ppu_addr, pix565};
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk_PPU or negedge n_reset_in) begin
    if (!n_reset_in) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Next FIFO head, bypassing storage when the pushed pixel becomes head.
  always_comb begin
    mem_req_d = (rd_d != wr_d);
    head_d    = fifo_q[rd_d[AW-1:0]];
    if (push && (rd_d == wr_q)) head_d = {ppu_addr, pix565};
  end

  // Registered memory port and end-of-frame pulse.
  always_ff @(posedge clk_PPU or negedge n_reset_in) begin
    if (!n_reset_in) begin
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mem_req_q <= mem_req_d;
      if (mem_req_d) begin
        mem_addr_q <= head_d[39:16];
        mem_data_q <= head_d[15:0];
      end
      frame_done_q <= pop && (mem_addr_q == LAST);
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign frame_done = frame_done_q;

`ifdef PPU_FB_STATS_EN
  logic        overflow_q;
  logic        addr_err_q;
  logic [15:0] drop_cnt_q;

  // Sticky error flags and saturating drop counter.
  always_ff @(posedge clk_PPU or negedge n_reset_in) begin
    if (!n_reset_in) begin
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (mismatch) addr_err_q <= 1'b1;
      if (drop && (drop_cnt_q != 16'hffff)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign overflow = overflow_q;
  assign addr_err = addr_err_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign overflow = 1'b0;
  assign addr_err = 1'b0;
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Scoreboard bench for ppu_fb_writer. The frame is shortened to 64 pixels
// so a full frame (and its wrap) fits in a short run.
module tb_ppu_fb_writer;

  localparam logic [23:0] BASE      = 24'hf00000;
  localparam int          TB_PIXELS = 64;
  localparam logic [23:0] LAST      = 24'hf0003f;

  logic        clk_PPU = 1'b0;
  logic        n_reset_in = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] ppu_addr = '0;
  logic [23:0] ppu_rgb = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic        frame_done;
  logic        synced;
  logic        overflow;
  logic        addr_err;
  logic [15:0] drop_cnt;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  bit          prev_last = 1'b0;
  logic [39:0] exp_q [$];
  logic [39:0] mon_e;

  ppu_fb_writer #(.BASE(BASE), .PIXELS(TB_PIXELS), .DEPTH(16)) dut (
    .clk_PPU(clk_PPU), .n_reset_in(n_reset_in), .in_valid(in_valid),
    .ppu_addr(ppu_addr), .ppu_rgb(ppu_rgb), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_data(mem_data),
    .frame_done(frame_done), .synced(synced), .overflow(overflow),
    .addr_err(addr_err), .drop_cnt(drop_cnt)
  );

  always #5 clk_PPU = ~clk_PPU;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  function automatic logic [23:0] col(input int i);
    return {8'(i * 7 + 3), 8'(i * 13 + 64), 8'(i * 29 + 200)};
  endfunction

  // Monitor: compare every accepted write and every frame_done pulse.
  always @(negedge clk_PPU) begin
    if (n_reset_in) begin
      if (frame_done || prev_last) begin
        chk("frame_done", 40'(frame_done), 40'(prev_last));
        if (frame_done) fd_cnt++;
      end
      prev_last = mem_req && mem_ack && (mem_addr == LAST);
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected none", mem_addr, mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write", {mem_addr, mem_data}, mon_e);
        end
      end
    end
  end

  task automatic do_reset();
    n_reset_in = 1'b0;
    in_valid   = 1'b0;
    mem_ack    = 1'b0;
    repeat (2) @(posedge clk_PPU);
    #1;
    exp_q.delete();
    prev_last  = 1'b0;
    fd_cnt     = 0;
    n_reset_in = 1'b1;
    @(posedge clk_PPU);
    #1;
  endtask

  task automatic pix(input logic [23:0] a, input logic [23:0] c, input bit ex);
    in_valid = 1'b1;
    ppu_addr = a;
    ppu_rgb  = c;
    if (ex) exp_q.push_back({a, pack(c)});
    @(posedge clk_PPU);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_PPU);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk_PPU);
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_mem_req", 40'(mem_req), 40'd0);
    chk("rst_mem_addr", 40'(mem_addr), 40'd0);
    chk("rst_mem_data", 40'(mem_data), 40'd0);
    chk("rst_synced", 40'(synced), 40'd0);
    chk("rst_frame_done", 40'(frame_done), 40'd0);
    chk("rst_stats", {22'd0, overflow, addr_err, drop_cnt}, 40'd0);

    // 1: short stream from BASE, ack held high
    mem_ack = 1'b1;
    pix(BASE, 24'hff0000, 1'b1);
    chk("t1_req_after_push", 40'(mem_req), 40'd1);
    chk("t1_addr", 40'(mem_addr), 40'hf00000);
    chk("t1_data", 40'(mem_data), 40'hf800);
    for (int i = 1; i < 4; i++) pix(BASE + 24'(i), 24'hff0000, 1'b1);
    drain();
    chk("t1_req_idle", 40'(mem_req), 40'd0);

    // 2: stream starting off-frame is ignored until BASE
    do_reset();
    mem_ack = 1'b1;
    for (int i = 5; i < 8; i++) pix(BASE + 24'(i), 24'h00ff00, 1'b0);
    chk("t2_synced_pre", 40'(synced), 40'd0);
    chk("t2_req_pre", 40'(mem_req), 40'd0);
    pix(BASE, 24'h00ff00, 1'b1);
    chk("t2_synced", 40'(synced), 40'd1);
    chk("t2_head", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 24'hf00000});
    pix(BASE + 24'd1, 24'h0000ff, 1'b1);
    drain();

    // 3: overflow with ack held low, then drain 16 entries
    do_reset();
    for (int i = 0; i < 16; i++) pix(BASE + 24'(i), col(i), 1'b1);
    pix(BASE + 24'd16, col(16), 1'b0);
    chk("t3_synced_after_drop", 40'(synced), 40'd0);
    chk("t3_head_stable", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 24'hf00000});
`ifdef PPU_FB_STATS_EN
    chk("t3_overflow", 40'(overflow), 40'd1);
    chk("t3_drop_cnt", 40'(drop_cnt), 40'd1);
`endif
    pix(BASE + 24'd17, col(17), 1'b0);
`ifdef PPU_FB_STATS_EN
    chk("t3_sync_discard_uncounted", 40'(drop_cnt), 40'd1);
`endif
    mem_ack = 1'b1;
    drain();
    chk("t3_req_idle", 40'(mem_req), 40'd0);

    // 6: simultaneous pop and push while full
    do_reset();
    for (int i = 0; i < 16; i++) pix(BASE + 24'(i), col(i + 40), 1'b1);
    mem_ack = 1'b1;
    pix(BASE + 24'd16, col(56), 1'b1);
    mem_ack = 1'b0;
    chk("t6_synced_no_drop", 40'(synced), 40'd1);
`ifdef PPU_FB_STATS_EN
    chk("t6_drop_cnt_same", 40'(drop_cnt), 40'd0);
    chk("t6_overflow_clear", 40'(overflow), 40'd0);
`endif
    pix(BASE + 24'd17, col(57), 1'b0);
    chk("t6_full_at_16", 40'(synced), 40'd0);
    mem_ack = 1'b1;
    drain();

    // 5: out-of-sequence address, then re-sync
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i <= 16; i++) pix(BASE + 24'(i), col(i + 80), 1'b1);
    pix(BASE + 24'h20, col(99), 1'b0);
    chk("t5_synced_lost", 40'(synced), 40'd0);
`ifdef PPU_FB_STATS_EN
    chk("t5_addr_err", 40'(addr_err), 40'd1);
`endif
    pix(BASE + 24'h21, col(100), 1'b0);
    chk("t5_still_sync", 40'(synced), 40'd0);
    pix(BASE, col(101), 1'b1);
    chk("t5_resync", 40'(synced), 40'd1);
    pix(BASE + 24'd1, col(102), 1'b1);
    pix(BASE, col(103), 1'b1);
    chk("t5_base_resync_in_run", 40'(synced), 40'd1);
    pix(BASE + 24'd1, col(104), 1'b1);
    drain();

    // 4: full frame, frame_done pulse, seamless wrap to the next frame
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < TB_PIXELS; i++) pix(BASE + 24'(i), col(i), 1'b1);
    pix(BASE, col(200), 1'b1);
    pix(BASE + 24'd1, col(201), 1'b1);
    chk("t4_synced_wrap", 40'(synced), 40'd1);
`ifdef PPU_FB_STATS_EN
    chk("t4_no_addr_err", 40'(addr_err), 40'd0);
`endif
    drain();
    chk("t4_frame_done_count", 40'(fd_cnt), 40'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
